// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_pkg
//  Description : Shared helpers for the N-channel stream multiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

    // Width of a channel index; a single channel still gets a 1-bit index.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : stream_mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter_n
//  Description : Combinational round-robin priority search. Grants the first
//                requesting channel at or after ptr, wrapping N_CH-1 -> 0.
//                Output is one-hot (or zero) plus the granted index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_n
    import stream_mux_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]            req,
    input  logic [sel_width(N_CH)-1:0] ptr,
    output logic [N_CH-1:0]            grant,
    output logic [sel_width(N_CH)-1:0] grant_idx
);

    localparam int c_SEL_W = sel_width(N_CH);

    int   w_idx;
    logic w_found;

    // Walk the channels starting at ptr; the first requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = 0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N_CH) begin
                w_idx = w_idx - N_CH;
            end
            if (!w_found && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_idx    = c_SEL_W'(w_idx);
                w_found      = 1'b1;
            end
        end
    end

endmodule : rr_arbiter_n
`default_nettype wire

// File: rtl/stream_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : stream_mux_n
//  Description : N-channel valid/ready stream multiplexer with round-robin
//                arbitration and a registered output stage (1-cycle latency,
//                full throughput). Optional packet lock enabled by the macro
//                STREAM_MUX_LAST_LOCK_EN: once a packet starts on a channel,
//                the grant stays there until its in_last beat transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = sel_width(N_CH)   // keep at default; sizes the arbiter
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic [N_CH*WIDTH-1:0]  in_data,
    input  logic [N_CH-1:0]        in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SEL_W-1:0]       out_sel
);

    logic [SEL_W-1:0] r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;

    logic [N_CH-1:0]  w_req;
    logic [N_CH-1:0]  w_grant;
    logic [SEL_W-1:0] w_gidx;
    logic [SEL_W-1:0] w_ptr_next;
    logic [WIDTH-1:0] w_gdata;
    logic             w_load;
    logic             w_any;
    logic             w_xfer;
    logic             w_adv;

`ifdef STREAM_MUX_LAST_LOCK_EN
    logic             r_lock;
    logic [SEL_W-1:0] r_lock_ch;

    // While locked, only the owning channel may request.
    always_comb begin
        w_req = in_valid;
        if (r_lock) begin
            w_req = in_valid & (N_CH'(1) << r_lock_ch);
        end
    end

    // Pointer moves on only when a packet closes.
    assign w_adv = w_xfer && in_last[w_gidx];

    // Lock on a non-last beat, release on the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock    <= 1'b0;
            r_lock_ch <= '0;
        end else if (w_xfer) begin
            r_lock    <= !in_last[w_gidx];
            r_lock_ch <= w_gidx;
        end
    end
`else
    logic w_unused_last;

    assign w_req         = in_valid;
    assign w_adv         = w_xfer;
    assign w_unused_last = ^in_last;
`endif

    rr_arbiter_n #(
        .N_CH      (N_CH)
    ) u_arb (
        .req       (w_req),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_gidx)
    );

    // Output register may take a new beat when empty or being drained.
    assign w_load     = !r_out_valid || out_ready;
    assign w_any      = |w_grant;
    assign w_xfer     = w_load && w_any && !rst;
    assign in_ready   = w_grant & {N_CH{w_load && !rst}};
    assign w_gdata    = in_data[int'(w_gidx)*WIDTH +: WIDTH];
    assign w_ptr_next = (w_gidx == SEL_W'(N_CH - 1)) ? '0 : w_gidx + SEL_W'(1);

    // Output stage: load granted beat, go empty when nothing to load, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gdata;
                r_out_sel   <= w_gidx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer: one past the last granted channel, with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_adv) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule : stream_mux_n
`default_nettype wire

// File: tb/tb_stream_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_mux_n
//  Description : Directed self-checking bench for stream_mux_n. Uses a 4-channel
//                and a 5-channel instance. Packet-lock scenario is included when
//                STREAM_MUX_LAST_LOCK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_n;

    logic        clk = 1'b0;
    logic        rst;

    // 4-channel instance
    logic [3:0]  v4, r4, l4;
    logic [31:0] d4;
    logic        ov4, or4;
    logic [7:0]  od4;
    logic [1:0]  os4;

    // 5-channel instance
    logic [4:0]  v5, r5, l5;
    logic [39:0] d5;
    logic        ov5, or5;
    logic [7:0]  od5;
    logic [2:0]  os5;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_mux_n #(.N_CH(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(v4), .in_ready(r4), .in_data(d4), .in_last(l4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_sel(os4)
    );

    stream_mux_n #(.N_CH(5), .WIDTH(8)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(v5), .in_ready(r5), .in_data(d5), .in_last(l5),
        .out_valid(ov5), .out_ready(or5), .out_data(od5), .out_sel(os5)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        v4  = 4'hF;  l4 = 4'hF; or4 = 1'b1;
        d4  = {8'h44, 8'h33, 8'h22, 8'h11};
        v5  = 5'h00; l5 = 5'h1F; or5 = 1'b1;
        d5  = {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};

        // Reset held 2 cycles with all inputs valid
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_out_valid", 32'(ov4), 32'h0);
            check("rst_out_data",  32'(od4), 32'h0);
            check("rst_in_ready",  32'(r4),  32'h0);
            check("rst_out_valid5", 32'(ov5), 32'h0);
        end

        // Release: first grant is channel 0
        rst = 1'b0;
        #1;
        check("first_grant", 32'(r4), 32'h1);

        // Fairness: 0,1,2,3,0,1 one beat per cycle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fair_valid", 32'(ov4), 32'h1);
            check("fair_sel",   32'(os4), 32'(i % 4));
            check("fair_data",  32'(od4), 32'h11 * 32'((i % 4) + 1));
            check("fair_ready", 32'(r4),  32'h1 << ((i + 1) % 4));
        end

        // Backpressure: 0xA5 from ch2 (ptr is 2 now)
        v4 = 4'b0100;
        d4 = {8'h44, 8'hA5, 8'h22, 8'h11};
        #1;
        check("bp_ready_ch2", 32'(r4), 32'h4);
        @(negedge clk);
        or4 = 1'b0;
        v4  = 4'hF;
        d4[23:16] = 8'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_data",  32'(od4), 32'hA5);
            check("bp_sel",   32'(os4), 32'h2);
            check("bp_valid", 32'(ov4), 32'h1);
            check("bp_ready", 32'(r4),  32'h0);
            @(negedge clk);
        end
        or4 = 1'b1;
        #1;
        check("bp_release_ready", 32'(r4), 32'h8);
        @(negedge clk);
        check("bp_next_sel",  32'(os4), 32'h3);
        check("bp_next_data", 32'(od4), 32'h44);

        // Idle drain: nothing valid, beat leaves, data holds
        v4 = 4'h0;
        @(negedge clk);
        check("drain_valid", 32'(ov4), 32'h0);
        check("drain_data",  32'(od4), 32'h44);
        check("drain_sel",   32'(os4), 32'h3);

        // Wrap/sparse on 5 channels: move ptr to 2 via one ch1 beat
        v5 = 5'b00010;
        #1;
        check("w5_ready_ch1", 32'(r5), 32'h02);
        @(negedge clk);
        check("w5_sel_a",  32'(os5), 32'h1);
        check("w5_data_a", 32'(od5), 32'hB1);
        v5 = 5'b10010;
        #1;
        check("w5_ready_ch4", 32'(r5), 32'h10);
        @(negedge clk);
        check("w5_sel_b",  32'(os5), 32'h4);
        check("w5_data_b", 32'(od5), 32'hB4);
        check("w5_ready_wrap", 32'(r5), 32'h02);
        @(negedge clk);
        check("w5_sel_c",  32'(os5), 32'h1);
        check("w5_ready_c", 32'(r5), 32'h10);
        @(negedge clk);
        check("w5_sel_d",  32'(os5), 32'h4);
        check("w5_valid_d", 32'(ov5), 32'h1);
        v5 = 5'b00000;
        @(negedge clk);
        check("w5_idle", 32'(ov5), 32'h0);

`ifdef STREAM_MUX_LAST_LOCK_EN
        // Packet lock: ch0 sends 3 beats (last on 3rd) while ch1 waits (ptr is 0)
        v4 = 4'b0011;
        l4 = 4'b1110;
        #1;
        check("lock_ready_0", 32'(r4), 32'h1);
        @(negedge clk);
        check("lock_sel_1",   32'(os4), 32'h0);
        check("lock_ready_1", 32'(r4),  32'h1);
        @(negedge clk);
        check("lock_sel_2",   32'(os4), 32'h0);
        l4 = 4'b1111;
        #1;
        check("lock_ready_2", 32'(r4),  32'h1);
        @(negedge clk);
        check("lock_sel_3",   32'(os4), 32'h0);
        check("lock_ready_3", 32'(r4),  32'h2);
        @(negedge clk);
        check("lock_sel_ch1", 32'(os4), 32'h1);
        v4 = 4'h0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stream_mux_n
`default_nettype wire

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-channel streaming multiplexer with valid/ready handshakes, round-robin arbitration and a registered output stage. Successor to the fixed 4-bit 2:1/4:1 combinational muxes: it generalises channel count and data width and adds flow control and fairness. It sits between several producer streams and one consumer in datapath/pipeline designs.

## Interface
- `N_CH`, default 4: number of input channels, ≥1; need not be a power of two.
- `WIDTH`, default 8: data width per channel, ≥1.
- `SEL_W`, default `$clog2(N_CH)` (min 1): width of the channel index.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  N_CH  per-channel valid.
- `in_ready`  out  N_CH  per-channel ready; combinational from state and `out_ready`.
- `in_data`  in  N_CH×WIDTH  packed channel data; channel i at `[i*WIDTH +: WIDTH]`.
- `in_last`  in  N_CH  per-channel end-of-packet flag; used only with `STREAM_MUX_LAST_LOCK_EN`.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  consumer accepts the beat.
- `out_data`  out  WIDTH  registered data.
- `out_sel`  out  SEL_W  index of the channel that supplied `out_data`.

## Operation
- Transfer on any interface occurs when valid && ready in the same cycle.
- Load enable: `load = !out_valid || out_ready`.
- Arbiter: among asserted `in_valid`, grant the first channel at or after pointer `ptr`, searching upward and wrapping from N_CH-1 to 0. Exactly one or zero grants per cycle.
- `in_ready[i] = load && grant[i]`. `in_ready` for non-granted channels is 0.
- On input transfer from channel g: `out_data<=in_data[g]`, `out_sel<=g`, `out_valid<=1`, `ptr<=(g==N_CH-1)?0:g+1`.
- If `load` and no `in_valid`: `out_valid<=0`; `out_data`/`out_sel` hold.
- If `!load`: all output registers and `ptr` hold; output stable while `out_valid && !out_ready`.
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`, lock state clear. Reset mid-stream discards the held beat; the in-flight `in_ready` in that cycle must be 0 (gated by `rst`).
- N_CH=1: arbiter degenerates to pass-through; `out_sel` always 0.
- `ptr` never takes values ≥ N_CH.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 beat/cycle sustained when `out_ready` held high (simultaneous output drain and input load in one cycle).
- `in_ready` depends combinationally on `out_ready`; no combinational path from `in_valid` of channel i to `in_ready` of channel i other than through the arbiter.
- Fairness: with all channels continuously valid, grants cycle 0,1,…,N_CH-1,0,… with no channel waiting more than N_CH-1 grants.

## Configuration
- Macro `STREAM_MUX_LAST_LOCK_EN`.
- Defined: after a transfer from channel g with `in_last[g]=0`, grant is locked to g (others see `in_ready=0`, even if g is not valid) until a transfer with `in_last[g]=1`; `ptr` advances only on the last beat. Lock cleared by reset.
- Not defined: `in_last` ignored; arbitration per beat as above.

## Structure
- Package `stream_mux_pkg`: function `sel_width(n)` returning `max(1,$clog2(n))`; no other shared types.
- Sub-module `rr_arbiter_n` (params `N_CH`; ports `req`, `ptr`, `grant` one-hot, `grant_idx`): purely combinational priority search with wrap. Registers, lock logic and data mux stay in `stream_mux_n`.

## Test plan
- Reset: assert `rst` 2 cycles with all `in_valid=1` -> `out_valid=0`, `out_data=0`, `in_ready=0` throughout; first grant after release is channel 0.
- Fairness, N_CH=4, all valid, `out_ready=1` -> `out_sel` sequence 0,1,2,3,0,1 on consecutive cycles, one beat per cycle.
- Backpressure: beat 0xA5 from ch2, hold `out_ready=0` 3 cycles -> `out_data=0xA5`, `out_sel=2` stable, all `in_ready=0`; release -> next beat loads same cycle.
- Wrap/sparse, N_CH=5: only ch4 and ch1 valid, ptr=2 -> grant ch4, then ch1, then ch4; `ptr` never ≥5.
- Idle drain: one beat then no valid, `out_ready=1` -> `out_valid` high 1 cycle then low, `out_data` holds.
- With `STREAM_MUX_LAST_LOCK_EN`: ch0 sends 3 beats (last on 3rd) while ch1 valid -> ch1 `in_ready=0` until ch0 last transfer, then ch1 granted next cycle.
